// File: rtl/fpm_dram_controller.sv
// Fast-page-mode DRAM controller for a 68000 bus: windowed decode, row/column mux for 1-2 RAS banks,
// per-byte CAS, and CAS-before-RAS refresh with enforced RAS precharge.
module fpm_dram_controller #(
  parameter int          ADDR_BITS        = 10,
  parameter int          BANKS            = 2,
  parameter logic [23:0] DRAM_BASE        = 24'h100000,
  parameter int          REFRESH_CYCLES   = 240,
  parameter int          PRECHARGE_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 AS,
  input  logic                 UDS,
  input  logic                 LDS,
  input  logic                 RW,
  input  logic [23:0]          ADDR_IN,
  output logic [ADDR_BITS-1:0] ADDR_OUT,
  output logic [BANKS-1:0]     RAS,
  output logic                 CASU,
  output logic                 CASL,
  output logic                 WE,
  output logic                 DTACK_DRAM
);

  localparam int OB  = 2*ADDR_BITS + 2;
  localparam int RCW = $clog2(REFRESH_CYCLES);
  localparam int PCW = $clog2(PRECHARGE_CYCLES + 1);
  localparam logic [24:0] WIN_LO = {1'b0, DRAM_BASE};
  localparam logic [24:0] WIN_HI = WIN_LO + (25'(BANKS) << (OB-1));

  typedef enum logic [3:0] {
    S_IDLE, S_ROW, S_MUX, S_COL, S_ACK, S_PRE, S_REF_CAS, S_REF_RAS, S_REF_DONE
  } state_t;

  state_t                 r_state, w_nstate;
  logic [ADDR_BITS-1:0]   r_addr, w_addr;
  logic [BANKS-1:0]       r_ras, w_ras, w_ras_bank;
  logic                   r_casu, w_casu, r_casl, w_casl, r_we, w_we, r_dtack, w_dtack;
  logic                   r_bank, w_bank_n;
  logic [PCW-1:0]         r_pre_cnt, w_pre_n;
  logic [RCW-1:0]         r_ref_cnt;
  logic                   r_ref_pend;
  logic                   w_ref_exp, w_ce, w_rel, w_bank;
  logic [OB-1:0]          w_off;
  logic [ADDR_BITS-1:0]   w_row, w_col;
  logic [1:0]             w_unused_bits;

  assign w_ce  = ~AS && ({1'b0, ADDR_IN} >= WIN_LO) && ({1'b0, ADDR_IN} < WIN_HI);
  assign w_off = ADDR_IN[OB-1:0] - DRAM_BASE[OB-1:0];
  assign w_row = w_off[ADDR_BITS:1];
  assign w_col = w_off[2*ADDR_BITS:ADDR_BITS+1];
  assign w_bank = (BANKS == 2) ? w_off[OB-1] : 1'b0;
  assign w_unused_bits = {w_off[OB-1], w_off[0]};

  assign w_ref_exp = (r_ref_cnt == RCW'(REFRESH_CYCLES - 1));

  always_comb begin
    for (int b = 0; b < BANKS; b++) w_ras_bank[b] = (r_bank != 1'(b));
  end

  always_comb begin
    w_nstate = r_state;
    w_addr   = r_addr;
    w_ras    = r_ras;
    w_casu   = r_casu;
    w_casl   = r_casl;
    w_we     = r_we;
    w_dtack  = r_dtack;
    w_bank_n = r_bank;
    w_pre_n  = r_pre_cnt;
    w_rel    = 1'b0;
    case (r_state)
      // The expiry term lets refresh win over a CE arriving on the same edge.
      S_IDLE: begin
        if (r_ref_pend || w_ref_exp) w_nstate = S_REF_CAS;
        else if (w_ce) begin
          w_addr   = w_row;
          w_bank_n = w_bank;
          w_nstate = S_ROW;
        end
      end
      S_ROW: begin
        if (AS) w_rel = 1'b1;
        else begin
          w_ras    = w_ras_bank;
          w_nstate = S_MUX;
        end
      end
      S_MUX: begin
        if (AS) w_rel = 1'b1;
        else begin
          w_addr   = w_col;
          w_we     = RW;
          w_nstate = S_COL;
        end
      end
      S_COL: begin
        if (AS) w_rel = 1'b1;
        else begin
          w_casu   = UDS;
          w_casl   = LDS;
          w_nstate = S_ACK;
        end
      end
      S_ACK: begin
        if (AS) w_rel = 1'b1;
        else    w_dtack = 1'b0;
      end
      S_PRE: begin
        if (r_pre_cnt == PCW'(PRECHARGE_CYCLES - 1)) w_nstate = S_IDLE;
        else w_pre_n = r_pre_cnt + 1'b1;
      end
      S_REF_CAS: begin
        w_casu   = 1'b0;
        w_casl   = 1'b0;
        w_nstate = S_REF_RAS;
      end
      S_REF_RAS: begin
        w_ras    = '0;
        w_nstate = S_REF_DONE;
      end
      S_REF_DONE: begin
        w_ras    = '1;
        w_casu   = 1'b1;
        w_casl   = 1'b1;
        w_pre_n  = '0;
        w_nstate = S_PRE;
      end
      default: w_nstate = S_IDLE;
    endcase
    if (w_rel) begin
      w_addr   = '0;
      w_ras    = '1;
      w_casu   = 1'b1;
      w_casl   = 1'b1;
      w_we     = 1'b1;
      w_dtack  = 1'b1;
      w_pre_n  = '0;
      w_nstate = S_PRE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_ras      <= '1;
      r_casu     <= 1'b1;
      r_casl     <= 1'b1;
      r_we       <= 1'b1;
      r_dtack    <= 1'b1;
      r_bank     <= 1'b0;
      r_pre_cnt  <= '0;
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_addr    <= w_addr;
      r_ras     <= w_ras;
      r_casu    <= w_casu;
      r_casl    <= w_casl;
      r_we      <= w_we;
      r_dtack   <= w_dtack;
      r_bank    <= w_bank_n;
      r_pre_cnt <= w_pre_n;
      r_ref_cnt <= w_ref_exp ? '0 : r_ref_cnt + 1'b1;
      // A new expiry outranks the clear so a request landing during REF_CAS is not lost.
      if (w_ref_exp)                  r_ref_pend <= 1'b1;
      else if (r_state == S_REF_CAS)  r_ref_pend <= 1'b0;
    end
  end

  assign ADDR_OUT   = r_addr;
  assign RAS        = r_ras;
  assign CASU       = r_casu;
  assign CASL       = r_casl;
  assign WE         = r_we;
  assign DTACK_DRAM = r_dtack;

endmodule

// File: tb/tb_fpm_dram_controller.sv
// Scoreboard bench for fpm_dram_controller: stimulus queues expected output changes with their
// edge number; a negedge monitor pops and compares each observed change.
module tb_fpm_dram_controller;
  logic        CLK = 1'b0, RST = 1'b0, AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
  logic [23:0] ADDR_IN = '0;
  logic [9:0]  ADDR_OUT;
  logic [1:0]  RAS;
  logic        CASU, CASL, WE, DTACK_DRAM;

  typedef struct packed {
    logic [9:0] a; logic [1:0] r; logic cu; logic cl; logic w; logic d;
  } obs_t;
  typedef struct { int c; obs_t o; } exp_t;

  localparam obs_t IDLE_O = {10'h000, 2'b11, 4'b1111};

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  obs_t last, cur;

  fpm_dram_controller dut (
    .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .ADDR_IN(ADDR_IN),
    .ADDR_OUT(ADDR_OUT), .RAS(RAS), .CASU(CASU), .CASL(CASL), .WE(WE), .DTACK_DRAM(DTACK_DRAM)
  );

  assign cur = {ADDR_OUT, RAS, CASU, CASL, WE, DTACK_DRAM};

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST)
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;

  function automatic string fmt(input obs_t o);
    return $sformatf("addr=%h ras=%b casu=%b casl=%b we=%b dtack=%b", o.a, o.r, o.cu, o.cl, o.w, o.d);
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && cur !== last) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change at edge %0d: got %s", cyc, fmt(cur));
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.o !== cur) begin
          n_bad++;
          $display("FAIL event: got edge %0d %s, want edge %0d %s", cyc, fmt(cur), e.c, fmt(e.o));
        end
      end
      last = cur;
    end
  end

  task automatic ev(input int c, input logic [9:0] a, input logic [1:0] r,
                    input logic cu, input logic cl, input logic w, input logic d);
    exp_t e;
    e.c = c;
    e.o = {a, r, cu, cl, w, d};
    q.push_back(e);
  endtask

  task automatic at_edge(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(posedge CLK); #1;
      g++;
    end
    if (cyc != n) begin
      n_bad++;
      $display("FAIL schedule: at edge %0d, wanted %0d", cyc, n);
    end
  endtask

  task automatic bus(input logic [23:0] ad, input logic u, input logic l, input logic rw);
    ADDR_IN = ad; UDS = u; LDS = l; RW = rw; AS = 1'b0;
  endtask

  task automatic idle_bus();
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
  endtask

  task automatic chk(input string nm, input obs_t want);
    n_cmp++;
    if (cur !== want) begin
      n_bad++;
      $display("FAIL %s: got %s, want %s", nm, fmt(cur), fmt(want));
    end
  endtask

  task automatic refresh_ev(input int x);
    ev(x+1, 10'h000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    ev(x+2, 10'h000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    ev(x+3, 10'h000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    #23;
    chk("reset_state", IDLE_O);
    @(negedge CLK); #2;
    RST = 1'b1;
    last = cur;
    mon_en = 1'b1;

    // word read, bank 0, row/col 0
    ev(11, 10'h000, 2'b10, 1, 1, 1, 1);
    ev(13, 10'h000, 2'b10, 0, 0, 1, 1);
    ev(14, 10'h000, 2'b10, 0, 0, 1, 0);
    ev(16, 10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(9);  bus(24'h100000, 0, 0, 1);
    at_edge(15); idle_bus();

    // low-byte write, bank 1
    ev(31, 10'h000, 2'b01, 1, 1, 1, 1);
    ev(32, 10'h000, 2'b01, 1, 1, 0, 1);
    ev(33, 10'h000, 2'b01, 1, 0, 0, 1);
    ev(34, 10'h000, 2'b01, 1, 0, 0, 0);
    ev(36, 10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(29); bus(24'h300001, 1, 0, 0);
    at_edge(35); idle_bus();

    // upper-byte read, row 0x26F col 0x357
    ev(50, 10'h26F, 2'b11, 1, 1, 1, 1);
    ev(51, 10'h26F, 2'b10, 1, 1, 1, 1);
    ev(52, 10'h357, 2'b10, 1, 1, 1, 1);
    ev(53, 10'h357, 2'b10, 0, 1, 1, 1);
    ev(54, 10'h357, 2'b10, 0, 1, 1, 0);
    ev(57, 10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(49); bus(24'h2ABCDE, 0, 1, 1);
    at_edge(56); idle_bus();

    // last word of window: bank 1, row/col 0x3FF, word write
    ev(70, 10'h3FF, 2'b11, 1, 1, 1, 1);
    ev(71, 10'h3FF, 2'b01, 1, 1, 1, 1);
    ev(72, 10'h3FF, 2'b01, 1, 1, 0, 1);
    ev(73, 10'h3FF, 2'b01, 0, 0, 0, 1);
    ev(74, 10'h3FF, 2'b01, 0, 0, 0, 0);
    ev(76, 10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(69); bus(24'h4FFFFE, 0, 0, 0);
    at_edge(75); idle_bus();

    // just outside either end of the window
    at_edge(89);  bus(24'h500000, 0, 0, 1);
    at_edge(97);  chk("oow_500000", IDLE_O); idle_bus();
    at_edge(109); bus(24'h0FFFFE, 0, 0, 0);
    at_edge(117); chk("oow_0FFFFE", IDLE_O); idle_bus();

    // abort with AS high sampled in MUX
    ev(140, 10'h26F, 2'b11, 1, 1, 1, 1);
    ev(141, 10'h26F, 2'b10, 1, 1, 1, 1);
    ev(142, 10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(139); bus(24'h2ABCDE, 0, 0, 1);
    at_edge(141); idle_bus();

    refresh_ev(240);

    // CE on the same edge the refresh interval expires
    refresh_ev(480);
    ev(486, 10'h26F, 2'b11, 1, 1, 1, 1);
    ev(487, 10'h26F, 2'b10, 1, 1, 1, 1);
    ev(488, 10'h357, 2'b10, 1, 1, 1, 1);
    ev(489, 10'h357, 2'b10, 0, 0, 1, 1);
    ev(490, 10'h357, 2'b10, 0, 0, 1, 0);
    ev(492, 10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(479); bus(24'h2ABCDE, 0, 0, 1);
    at_edge(491); idle_bus();

    // access requested during precharge waits for IDLE
    ev(496, 10'h000, 2'b10, 1, 1, 1, 1);
    ev(498, 10'h000, 2'b10, 0, 0, 1, 1);
    ev(499, 10'h000, 2'b10, 0, 0, 1, 0);
    ev(501, 10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(492); bus(24'h100000, 0, 0, 1);
    at_edge(500); idle_bus();

    refresh_ev(720);

    // reset pulse while in ACK
    ev(801, 10'h000, 2'b01, 1, 1, 1, 1);
    ev(802, 10'h000, 2'b01, 1, 1, 0, 1);
    ev(803, 10'h000, 2'b01, 1, 0, 0, 1);
    ev(804, 10'h000, 2'b01, 1, 0, 0, 0);
    ev(0,   10'h000, 2'b11, 1, 1, 1, 1);
    at_edge(799); bus(24'h300001, 1, 0, 0);
    at_edge(806); #1;
    RST = 1'b0;
    idle_bus();
    #1 chk("async_reset", IDLE_O);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;

    // refresh counter restarted from 0
    refresh_ev(240);
    at_edge(260);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: %0d left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpm_dram_controller.md
# fpm_dram_controller

Parametrised fast-page-mode DRAM controller for the 68000 bus, replacing the single-bank fixed controller. It decodes a configurable DRAM window and multiplexes row/column addresses for 1 or 2 SIMM banks. It drives per-bank RAS, per-byte CAS (UDS/LDS), WE and DTACK. It schedules CAS-before-RAS refresh from a programmable interval, with enforced RAS precharge. Sits between the CPU bus and the SIMM sockets; DTACK_DRAM feeds the board DTACK combiner.

## Interface
- ADDR_BITS, 10, DRAM row/column address width; each bank is 2^(2*ADDR_BITS+1) bytes.
- BANKS, 2, number of RAS banks; legal values 1 or 2.
- DRAM_BASE, 24'h100000, byte base of the DRAM window; window size is BANKS*2^(2*ADDR_BITS+1).
- REFRESH_CYCLES, 240, CLK cycles between refresh requests (≥ 16).
- PRECHARGE_CYCLES, 2, minimum CLK cycles RAS stays high after any access or refresh (≥ 1).

Ports:
- CLK  in  1  system clock. One clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- AS  in  1  68000 address strobe, active-low.
- UDS  in  1  upper data strobe, active-low.
- LDS  in  1  lower data strobe, active-low.
- RW  in  1  1 = read, 0 = write.
- ADDR_IN  in  24  CPU byte address.
- ADDR_OUT  out  ADDR_BITS  multiplexed DRAM address.
- RAS  out  BANKS  per-bank row strobe, active-low.
- CASU  out  1  upper-byte column strobe, active-low.
- CASL  out  1  lower-byte column strobe, active-low.
- WE  out  1  DRAM write enable, active-low.
- DTACK_DRAM  out  1  data acknowledge to CPU, active-low.

## Operation
- Reset: ADDR_OUT=0, RAS=all 1, CASU=CASL=1, WE=1, DTACK_DRAM=1. Refresh counter=0, refresh_pending=0, state=IDLE.
- Select: CE = AS low and DRAM_BASE ≤ ADDR_IN < window end. Offset OFF = ADDR_IN − DRAM_BASE.
- Address mapping: row = OFF[ADDR_BITS:1]; column = OFF[2*ADDR_BITS:ADDR_BITS+1]; bank = OFF[2*ADDR_BITS+1] when BANKS=2, else 0.
- Refresh counter: increments every cycle. On reaching REFRESH_CYCLES−1 it reloads 0 and sets refresh_pending. A second expiry while pending is absorbed (no queueing).
- States:
  - IDLE: if refresh_pending → REF_CAS (refresh has priority over a simultaneous CE). Else if CE: latch row into ADDR_OUT, latch bank → ROW.
  - ROW: RAS[bank]=0 → MUX.
  - MUX: ADDR_OUT=column; WE=RW → COL.
  - COL: CASU=UDS, CASL=LDS → ACK.
  - ACK: DTACK_DRAM=0; hold until AS sampled high. Then RAS, CAS, WE and DTACK all go inactive and ADDR_OUT=0 → PRE.
  - PRE: hold all strobes inactive for PRECHARGE_CYCLES cycles → IDLE.
  - REF_CAS: clear refresh_pending; CASU=CASL=0 → REF_RAS.
  - REF_RAS: all RAS=0 → REF_DONE.
  - REF_DONE: all RAS, CAS=1 → PRE.
- Abort: AS sampled high in ROW, MUX or COL → release all strobes, DTACK stays 1 → PRE.
- A CPU cycle held off by refresh or precharge stays pending while AS is low. It is serviced from IDLE with no lost access.
- Unselected addresses never touch any output.

## Timing
- Edge E0: IDLE samples CE. Then RAS low at E1, column on ADDR_OUT and WE valid at E2, CAS low at E3, DTACK low at E4.
- RAS-to-CAS is 2 cycles; row/column setup is ≥1 cycle before the respective strobe.
- Release: AS sampled high at edge Ek → all strobes high at Ek. IDLE is reached at Ek+PRECHARGE_CYCLES+1.
- Refresh: CAS low 1 cycle before RAS, RAS low for 1 cycle, then precharge. Refresh holds the controller busy for 3+PRECHARGE_CYCLES cycles.
- Worst-case added access latency from refresh = 3+PRECHARGE_CYCLES+1 cycles.
- RST low at any time forces reset values immediately, regardless of clock.

## Test plan
- Read at 0x100000, BANKS=2, AS/UDS/LDS low, RW=1 → RAS=2'b10 at E1, ADDR_OUT=0 at E2, CASU=CASL=0 at E3, DTACK_DRAM=0 at E4, WE stays 1. AS high → all inactive, IDLE after 3 cycles.
- Byte write to 0x300001 (bank 1), LDS only, RW=0 → RAS=2'b01, WE=0 from E2, CASL=0, CASU=1, DTACK at E4.
- Refresh: idle bus → refresh sequence repeats every 240 cycles. Order is CAS low, then both RAS low, then all high.
- Collision: CE asserted on the same edge refresh_pending sets → refresh runs first, then the access completes. DTACK arrives at E4+6 from first CE sample.
- Out-of-window access at 0x500000 or 0x0FFFFE → no output changes.
- Abort and reset: AS raised in MUX → RAS released, no DTACK, PRE entered. RST pulsed low while in ACK → all outputs inactive immediately, counter 0.
